// File: rtl/pwl_activation_unit_if.sv
// pwl_activation_unit_if: valid/ready beat bundle between the accumulator output and the activation unit
interface pwl_activation_unit_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              in_mode;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic [LANES-1:0]        out_sat;
  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/pwl_activation_unit.sv
// pwl_activation_unit: two-stage multi-lane identity/ReLU/PWL-sigmoid/PWL-tanh activation with valid/ready
module pwl_activation_unit #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 10,
  parameter int LANES  = 4
) (
  input logic                  clk,
  input logic                  rst,
  pwl_activation_unit_if.slave io
);
  typedef enum logic [1:0] {M_ID, M_RELU, M_SIG, M_TANH} mode_t;
  localparam logic [DATA_W-1:0] ONE  = DATA_W'(1 << FRAC_W);
  localparam logic [DATA_W-1:0] HALF = DATA_W'(1 << (FRAC_W - 1));
  localparam logic [DATA_W-1:0] T2   = DATA_W'((19 << FRAC_W) / 8);
  localparam logic [DATA_W-1:0] T3   = DATA_W'(5 << FRAC_W);
  localparam logic [DATA_W-1:0] C1   = DATA_W'((5 << FRAC_W) / 8);
  localparam logic [DATA_W-1:0] C2   = DATA_W'((27 << FRAC_W) / 32);
  localparam logic [DATA_W-1:0] MAXP = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MINN = {1'b1, {(DATA_W-1){1'b0}}};
  if (DATA_W < FRAC_W + 4) begin : g_bad_format
    $error("pwl_activation_unit: DATA_W must be at least FRAC_W+4");
  end
  logic  en;
  logic  s1_valid;
  mode_t s1_mode;
  logic  out_valid_q;
  assign en          = ~out_valid_q | io.out_ready;
  assign io.in_ready = en;
  assign io.out_valid = out_valid_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      s1_valid    <= io.in_valid;
      out_valid_q <= s1_valid;
    end
  end
  always_ff @(posedge clk) begin
    if (en && io.in_valid) s1_mode <= mode_t'(io.in_mode);
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0] z, x, a, z1, a1, p, s, y, q;
    logic [1:0]        r, r1;
    logic              sg1, st, qs;
    // tanh evaluates the sigmoid at 2z, clamped to the word range
    always_comb begin
      z = io.in_data[i*DATA_W +: DATA_W];
      x = io.in_mode == M_TANH
          ? (z[DATA_W-1] != z[DATA_W-2] ? (z[DATA_W-1] ? MINN : MAXP) : {z[DATA_W-2:0], 1'b0})
          : z;
      a = x == MINN ? MAXP : (x[DATA_W-1] ? -x : x);
      r = a >= T3 ? 2'd3 : a >= T2 ? 2'd2 : a >= ONE ? 2'd1 : 2'd0;
    end
    always_ff @(posedge clk) begin
      if (en && io.in_valid) begin
        z1  <= z;
        a1  <= a;
        r1  <= r;
        sg1 <= x[DATA_W-1];
      end
    end
    always_comb begin
      p  = r1 == 2'd3 ? ONE
         : r1 == 2'd2 ? (a1 >> 5) + C2
         : r1 == 2'd1 ? (a1 >> 3) + C1
         : (a1 >> 2) + HALF;
      s  = sg1 ? ONE - p : p;
      y  = s1_mode == M_ID   ? z1
         : s1_mode == M_RELU ? (z1[DATA_W-1] ? '0 : z1)
         : s1_mode == M_SIG  ? s
         : (s << 1) - ONE;
      st = s1_mode[1] && r1 == 2'd3;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        q  <= '0;
        qs <= 1'b0;
      end else if (en && s1_valid) begin
        q  <= y;
        qs <= st;
      end
    end
    assign io.out_data[i*DATA_W +: DATA_W] = q;
    assign io.out_sat[i] = qs;
  end
endmodule

// File: tb/tb_pwl_activation_unit.sv
// tb_pwl_activation_unit: randomized and directed stimulus checked against an arithmetic reference model
module tb_pwl_activation_unit;
  localparam int DW = 16;
  localparam int FW = 10;
  localparam int L  = 4;
  localparam int ONE = 1 << FW;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pwl_activation_unit_if #(.DATA_W(DW), .LANES(L)) bus();
  pwl_activation_unit #(.DATA_W(DW), .FRAC_W(FW), .LANES(L)) dut (.clk(clk), .rst(rst), .io(bus));
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit rdy_rand = 1'b0;
  bit lat_chk = 1'b1;
  logic [63:0] exp_d[$];
  logic [63:0] exp_s[$];
  int acc_q[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  // sigmoid straight from the region table, on plain integers
  function automatic int sig(input int z);
    int a, p;
    a = z < 0 ? -z : z;
    if (a > MAXV) a = MAXV;
    if (a >= 5 * ONE) p = ONE;
    else if (a >= ONE * 19 / 8) p = a / 32 + ONE * 27 / 32;
    else if (a >= ONE) p = a / 8 + ONE * 5 / 8;
    else p = a / 4 + ONE / 2;
    return z >= 0 ? p : ONE - p;
  endfunction
  function automatic void ref_act(input int m, input int z, output int r, output bit s);
    int t, az;
    az = z < 0 ? -z : z;
    s = 1'b0;
    case (m)
      0: r = z;
      1: r = z > 0 ? z : 0;
      2: begin r = sig(z); s = (az > MAXV ? MAXV : az) >= 5 * ONE; end
      default: begin
        t = 2 * z;
        if (t > MAXV) t = MAXV;
        if (t < MINV) t = MINV;
        r = 2 * sig(t) - ONE;
        s = 2 * az >= 5 * ONE;
      end
    endcase
  endfunction
  task automatic expect_beat(input logic [1:0] m, input logic [63:0] d);
    logic [63:0] ed = '0;
    logic [63:0] es = '0;
    for (int i = 0; i < L; i++) begin
      int z, r;
      bit s;
      z = int'($signed(d[i*DW +: DW]));
      ref_act(int'(m), z, r, s);
      ed[i*DW +: DW] = DW'(r);
      es[i] = s;
    end
    exp_d.push_back(ed);
    exp_s.push_back(es);
  endtask
  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction
  function automatic int rnd_lane();
    int edges[14] = '{1024, 1023, 2432, 2431, 5120, 5119, 2560, 2559, -1024, -2432, -5120, -2560, 32767, -32768};
    int k = int'($urandom_range(0, 3));
    return k == 0 ? int'($signed(DW'($urandom)))
         : k == 1 ? int'($urandom_range(0, 12000)) - 6000
         : edges[$urandom_range(0, 13)];
  endfunction
  task automatic send(input logic [1:0] m, input logic [63:0] d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept", bus.in_ready, 1'b1);
    acc_q.push_back(cyc);
    expect_beat(m, d);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_d.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 64'(exp_d.size()), 64'd0);
  endtask
  bit stalled = 1'b0;
  logic [63:0] pd, ps;
  always @(negedge clk) begin
    if (rst) stalled = 1'b0;
    else begin
      chk("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (stalled) begin
        chk("hold_valid", bus.out_valid, 1'b1);
        chk("hold_data", bus.out_data, pd);
        chk("hold_sat", 64'(bus.out_sat), ps);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_d.size() == 0) chk("extra_beat", bus.out_valid, 1'b0);
        else begin
          int a;
          chk("out_data", bus.out_data, exp_d.pop_front());
          chk("out_sat", 64'(bus.out_sat), exp_s.pop_front());
          a = acc_q.pop_front();
          if (lat_chk) chk("latency", 64'(cyc - a), 64'd2);
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      pd = bus.out_data;
      ps = 64'(bus.out_sat);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_mode  = 2'd0;
    bus.in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_out_sat", 64'(bus.out_sat), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    send(2'd2, pk(0, 1024, -1024, 3072));
    send(2'd2, pk(5120, -5120, 2432, 32767));
    send(2'd2, pk(-32768, 1023, 2431, 5119));
    send(2'd3, pk(512, -512, 2560, 0));
    send(2'd1, pk(-7, 300, 0, -32768));
    send(2'd0, pk(-32768, 32767, -1, 5));
    send(2'd3, pk(-32768, 32767, -2560, 2559));
    drain();
    lat_chk = 1'b0;
    rdy_rand = 1'b1;
    for (int k = 0; k < 48; k++) begin
      send(2'(k % 4), pk(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_rand = 1'b0;
    drain();
    lat_chk = 1'b1;
    send(2'd2, pk(100, 200, 300, 400));
    send(2'd3, pk(-100, -200, -300, -400));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_out_data", bus.out_data, 64'd0);
    rst = 1'b0;
    exp_d.delete();
    exp_s.delete();
    acc_q.delete();
    send(2'd2, pk(1024, -3072, 2432, -5120));
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
